// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// UART receive framer that sits directly behind the Rx baud generator. The
// generator's baud_clk level is edge-detected on the system clock; every
// rising edge is one oversample tick (OVERSAMPLE ticks per bit). The serial
// line is synchronised, a start bit is detected, every bit is voted 2-of-3
// around mid-bit, and one DATA_BITS-wide word is delivered per frame together
// with parity and stop status.
//
// Ports
//   clock        : system clock, all logic on posedge
//   reset_n      : asynchronous active-low reset
//   baud_clk     : oversampling clock level, synchronous to clock
//   rx_in        : raw serial line, idle high, asynchronous to clock
//   parity_type  : 00 none, 01 odd, 10 even, 11 none (sampled at frame start)
//   data_out     : last received word (held until the next done)
//   done         : one-clock pulse when a frame completes
//   parity_error : parity check failed on the last frame
//   stop_error   : stop bit sampled low on the last frame
//   busy         : high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 baud_clk,
    input  logic                 rx_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Three samples straddle the bit centre; the vote happens on the last one.
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SMP_VOTE = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q,      state_d;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 baud_d_q;
    logic [CNT_W-1:0]     tick_cnt_q,   tick_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 smp_a_q,      smp_a_d;
    logic                 smp_b_q,      smp_b_d;
    logic [1:0]           par_mode_q,   par_mode_d;
    logic                 perr_q,       perr_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 done_q,       done_d;
    logic                 perr_out_q,   perr_out_d;
    logic                 serr_q,       serr_d;
    logic                 busy_q,       busy_d;

    logic tick;
    logic majority;
    logic par_en;
    logic at_vote;
    logic at_last;

    always_comb begin
        tick     = baud_clk & ~baud_d_q;
        majority = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);
        par_en   = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
        at_vote  = (tick_cnt_q == SMP_VOTE);
        at_last  = (tick_cnt_q == CNT_LAST);

        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        smp_a_d    = smp_a_q;
        smp_b_d    = smp_b_q;
        par_mode_d = par_mode_q;
        perr_d     = perr_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        perr_out_d = perr_out_q;
        serr_d     = serr_q;

        if (tick) begin
            if (state_q != S_IDLE) begin
                tick_cnt_d = tick_cnt_q + 1'b1;
                if (tick_cnt_q == SMP_A) smp_a_d = rx_s_q;
                if (tick_cnt_q == SMP_B) smp_b_d = rx_s_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        // The detecting tick is tick 0 of the start bit.
                        state_d    = S_START;
                        tick_cnt_d = CNT_W'(1);
                        par_mode_d = parity_type;
                        perr_d     = 1'b0;
                    end
                end
                S_START: begin
                    if (at_vote && majority) begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end else if (at_last) begin
                        state_d    = S_DATA;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first: shift right so it ends up in bit 0.
                    if (at_vote) shift_d = {majority, shift_q[DATA_BITS-1:1]};
                    if (at_last) begin
                        tick_cnt_d = '0;
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_vote) perr_d = ((^shift_q) ^ majority) != (par_mode_q == 2'b01);
                    if (at_last) begin
                        state_d    = S_STOP;
                        tick_cnt_d = '0;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so a following start bit can be caught.
                    if (at_vote) begin
                        data_out_d = shift_q;
                        serr_d     = ~majority;
                        perr_out_d = perr_q;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            baud_d_q   <= 1'b0;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            smp_a_q    <= 1'b0;
            smp_b_q    <= 1'b0;
            par_mode_q <= 2'b00;
            perr_q     <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            perr_out_q <= 1'b0;
            serr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_s_q     <= rx_meta_q;
            baud_d_q   <= baud_clk;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            smp_a_q    <= smp_a_d;
            smp_b_q    <= smp_b_d;
            par_mode_q <= par_mode_d;
            perr_q     <= perr_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            perr_out_q <= perr_out_d;
            serr_q     <= serr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out     = data_out_q;
    assign done         = done_q;
    assign parity_error = perr_out_q;
    assign stop_error   = serr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Bench for uart_rx_frame. The serial line is described tick by tick in a
// queue; frames are built from their byte/parity/stop description, and the
// expected result of each frame is computed from the UART framing rules
// (majority voting means a one-tick glitch never changes a bit).
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       baud_clk;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       done;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    always #10 clock = ~clock;

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .baud_clk     (baud_clk),
        .rx_in        (rx_in),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .done         (done),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
        logic       bz;
        int         t;
    } obs_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         tick_no = 0;
    int         hold_hi = 1;
    logic [7:0] last_d = 8'h00;
    bit         line_q[$];
    obs_t       obs_q[$];
    exp_t       exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every done pulse is captured together with the outputs and tick number.
    always @(negedge clock) begin
        if (done === 1'b1)
            obs_q.push_back('{d: data_out, pe: parity_error, se: stop_error, bz: busy, t: tick_no});
    end

    // One oversample tick: line settles through the synchroniser, then baud_clk rises.
    task automatic do_tick(input bit v);
        rx_in = v;
        @(negedge clock);
        @(negedge clock);
        baud_clk = 1'b1;
        tick_no++;
        repeat (hold_hi) @(negedge clock);
        baud_clk = 1'b0;
        @(negedge clock);
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n && line_q.size() > 0; i++) do_tick(line_q.pop_front());
    endtask

    task automatic play_all();
        play(line_q.size());
    endtask

    task automatic push_level(input bit v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] pt, input bit pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (pt == 2'b01) return (ones % 2) == 0;
        if (pt == 2'b10) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    // Build one frame on the line and record what it should produce.
    // gbit: data bit carrying a one-tick inverted glitch at tick gtick (-1: none).
    task automatic push_frame(input logic [7:0] d, input logic [1:0] pt, input bit pbit,
                              input bit stop, input int gbit, input int gtick);
        bit has_par;
        has_par = (pt == 2'b01) || (pt == 2'b10);
        push_level(1'b0, 16);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 16; k++)
                line_q.push_back((b == gbit && k == gtick) ? ~d[b] : d[b]);
        if (has_par) push_level(pbit, 16);
        push_level(stop, 16);
        exp_q.push_back('{d: d, pe: exp_perr(d, pt, pbit), se: ~stop});
    endtask

    task automatic compare_frames(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, obs_q[i].d, exp_q[i].d);
            chk({tag, "_perr"}, obs_q[i].pe, exp_q[i].pe);
            chk({tag, "_serr"}, obs_q[i].se, exp_q[i].se);
            chk({tag, "_busy_at_done"}, obs_q[i].bz, 1'b0);
        end
        if (exp_q.size() > 0) last_d = exp_q[exp_q.size()-1].d;
        chk({tag, "_data_held"}, data_out, last_d);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int diff;
        logic [7:0] rd;
        logic [1:0] rpt;
        bit rpb, rstop;
        int rgb, rgap;

        reset_n = 1'b0;
        baud_clk = 1'b0;
        rx_in = 1'b1;
        parity_type = 2'b00;
        repeat (3) @(negedge clock);
        chk("rst_data", data_out, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_perr", parity_error, 1'b0);
        chk("rst_serr", stop_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        push_level(1'b1, 20);
        play_all();
        chk("idle_no_done", obs_q.size(), 0);

        // Basic byte, no parity
        parity_type = 2'b00;
        push_frame(8'hA5, 2'b00, 1'b0, 1'b1, -1, 0);
        push_level(1'b1, 16);
        play_all();
        compare_frames("basic_a5");

        // Parity on 0x37 (five ones)
        parity_type = 2'b10;
        push_frame(8'h37, 2'b10, 1'b1, 1'b1, -1, 0);
        push_level(1'b1, 16);
        play_all();
        compare_frames("even_ok");
        push_frame(8'h37, 2'b10, 1'b0, 1'b1, -1, 0);
        push_level(1'b1, 16);
        play_all();
        compare_frames("even_bad");
        parity_type = 2'b01;
        push_frame(8'h37, 2'b01, 1'b0, 1'b1, -1, 0);
        push_level(1'b1, 16);
        play_all();
        compare_frames("odd_ok");

        // Framing error, then a clean frame clears it
        parity_type = 2'b00;
        push_frame(8'h3C, 2'b00, 1'b0, 1'b0, -1, 0);
        push_level(1'b1, 20);
        play_all();
        compare_frames("stop_bad");
        push_frame(8'h55, 2'b00, 1'b0, 1'b1, -1, 0);
        push_level(1'b1, 16);
        play_all();
        compare_frames("stop_clear");

        // Short low pulse on an idle line is a false start
        push_level(1'b0, 4);
        push_level(1'b1, 12);
        play(10);
        chk("false_start_busy", busy, 1'b0);
        play_all();
        compare_frames("false_start");

        // Single-tick glitch at tick 8 of data bit 2
        push_frame(8'hFF, 2'b00, 1'b0, 1'b1, 2, 8);
        push_level(1'b1, 16);
        play_all();
        compare_frames("glitch_ff");

        // Back-to-back frames with no idle gap
        push_frame(8'h01, 2'b00, 1'b0, 1'b1, -1, 0);
        push_frame(8'h80, 2'b00, 1'b0, 1'b1, -1, 0);
        push_level(1'b1, 16);
        play_all();
        diff = (obs_q.size() == 2) ? obs_q[1].t - obs_q[0].t : 0;
        chk("b2b_spacing", (diff >= 159 && diff <= 161), 1'b1);
        compare_frames("b2b");

        // Break: line low for 308 ticks yields two zero frames with stop errors,
        // the second one starting right after the first one's mid-stop exit.
        push_level(1'b0, 308);
        push_level(1'b1, 20);
        exp_q.push_back('{d: 8'h00, pe: 1'b0, se: 1'b1});
        exp_q.push_back('{d: 8'h00, pe: 1'b0, se: 1'b1});
        play_all();
        diff = (obs_q.size() == 2) ? obs_q[1].t - obs_q[0].t : 0;
        chk("break_spacing", diff, 154);
        compare_frames("break");

        // Reset in the middle of data bit 3 aborts the frame
        push_frame(8'hC3, 2'b00, 1'b0, 1'b0, -1, 0);
        push_level(1'b1, 20);
        play_all();
        compare_frames("pre_reset");
        push_frame(8'h5A, 2'b00, 1'b0, 1'b1, -1, 0);
        void'(exp_q.pop_back());
        play(16 * 4 + 5);
        chk("mid_frame_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("abort_data", data_out, 8'h00);
        chk("abort_done", done, 1'b0);
        chk("abort_perr", parity_error, 1'b0);
        chk("abort_serr", stop_error, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        line_q.delete();
        push_level(1'b1, 40);
        play_all();
        last_d = 8'h00;
        compare_frames("after_reset");

        // Randomised frames; parity_type moves mid-frame, one frame sees stalled baud_clk
        for (int f = 0; f < 24; f++) begin
            rd    = 8'($urandom);
            rpt   = 2'($urandom_range(0, 3));
            rpb   = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 4) != 0);
            rgb   = int'($urandom_range(0, 8)) - 1;
            rgap  = rstop ? int'($urandom_range(0, 5)) : 16 + int'($urandom_range(0, 5));
            parity_type = rpt;
            push_frame(rd, rpt, rpb, rstop, rgb, int'($urandom_range(0, 15)));
            push_level(1'b1, rgap);
            play(20 + int'($urandom_range(0, 40)));
            parity_type = 2'($urandom);
            if (f == 5) begin
                repeat (60) @(negedge clock);
                chk("stall_lo_busy", busy, 1'b1);
                chk("stall_lo_data", data_out, last_d);
                chk("stall_lo_done", obs_q.size(), 0);
                hold_hi = 60;
                play(1);
                hold_hi = 1;
                chk("stall_hi_busy", busy, 1'b1);
                chk("stall_hi_data", data_out, last_d);
            end
            play_all();
            compare_frames("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #20ms;
        $display("FAIL timeout got=%0d exp=%0d", tick_no, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer directly downstream of the Rx baud generator.
- Consumes the generator's baud_clk level, which toggles at the oversampling rate. Each rising edge is one oversample tick, 16 ticks per bit.
- Runs entirely on the 50 MHz system clock. Synchronises the serial line, detects the start bit, majority-samples each bit, and delivers one 8-bit byte per frame with parity and stop status.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, ticks per bit; tick counter width is log2(OVERSAMPLE).

Ports:
- clock, input, 1, system clock (50 MHz), all logic on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- baud_clk, input, 1, oversampling clock level from the baud generator; synchronous to clock.
- rx_in, input, 1, raw serial line, idle high, asynchronous.
- parity_type, input, 2, 00 none, 01 odd, 10 even, 11 none.
- data_out, output, DATA_BITS, last received byte.
- done, output, 1, one-clock pulse when a frame completes.
- parity_error, output, 1, parity check failed on last frame.
- stop_error, output, 1, stop bit sampled low on last frame.
- busy, output, 1, high while a frame is in progress.

Behaviour:
- Reset (async, reset_n=0):
  - data_out=0, done=0, parity_error=0, stop_error=0, busy=0.
  - Synchroniser flops = 1; baud_clk_d = 0; FSM = IDLE; all counters 0.
- Reset mid-frame aborts the frame; no done is issued.
- rx_in passes through a 2-flop synchroniser (rx_s), adding 2 clocks of latency.
- tick = baud_clk & ~baud_clk_d, registered edge detect, single-clock pulse. All FSM actions below occur only on clocks where tick=1.
- tick_cnt (4 bits) counts 0..15 within each bit.
- Samples are taken at tick_cnt 7, 8 and 9. At tick_cnt==9 the bit value is the majority (2 of 3) of those samples.
- FSM states:
  - IDLE:
    - busy=0.
    - On tick with rx_s==0: go to START, tick_cnt=1, latch parity_type into par_mode.
  - START:
    - At tick_cnt 9: if majority==1, false start; return to IDLE with no outputs changed.
    - At tick_cnt 15: go to DATA with tick_cnt=0 and bit_idx=0.
  - DATA:
    - At tick_cnt 9: shift majority into the shift register MSB, shifting right, so the first bit received ends in bit 0.
    - At tick_cnt 15: if bit_idx==DATA_BITS-1, go to PARITY when par_mode is 01 or 10, else to STOP. Otherwise bit_idx++.
  - PARITY:
    - At tick_cnt 9: perr_next = (^shift ^ majority) != (par_mode==01).
    - At tick_cnt 15: go to STOP.
  - STOP:
    - At tick_cnt 9: data_out <= shift; stop_error <= ~majority; parity_error <= perr_next (0 when no parity).
    - Same clock: done=1 for exactly one clock; go to IDLE. The early exit allows resync during the back half of the stop bit.
- busy=1 in every state except IDLE, registered with the state.
- data_out and both error flags are held until the next done. done asserts even when an error flag is set.
- parity_type changes mid-frame have no effect on the frame in progress.
- Line held low (break) after a frame: IDLE starts a new frame on the next tick. That frame yields data_out=0x00 and stop_error=1.
- baud_clk stuck at either level: no ticks, FSM frozen, no outputs change.
- The tick counter wraps 15 to 0 only on bit transitions as listed above; no other wrap is legal.

Test Plan:
- Reset test: assert reset_n=0 mid-frame (during DATA, bit 3) -> all outputs 0 immediately; after release, the line idles high and no done is produced.
- Basic byte, parity_type=00: send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with stop=1 and a 16-tick bit period -> exactly one done pulse, data_out=0xA5, parity_error=0, stop_error=0, busy drops with done.
- Parity checks on byte 0x37 (five ones):
  - parity_type=10 (even), parity bit 1 -> parity_error=0.
  - parity_type=10 (even), parity bit 0 -> parity_error=1.
  - parity_type=01 (odd), parity bit 0 -> parity_error=0.
- Framing: send 0x3C with stop bit 0 -> done=1, data_out=0x3C, stop_error=1. The next clean frame 0x55 -> stop_error clears to 0.
- Glitch rejection and majority voting:
  - A low pulse of 4 ticks on the idle line -> false start, return to IDLE, no done.
  - A single-tick inverted glitch at tick 8 of data bit 2 of 0xFF -> data_out=0xFF (majority vote holds).
- Back-to-back frames with no idle gap, 0x01 then 0x80 -> two done pulses 160±1 ticks apart, data_out=0x01 then 0x80, no errors.
